uart_rx16: RTL
==============

// Module: uart_rx16
// PURPOSE
//  Receive side of the UART peripheral. Oversamples rxd on the 16x-baud uart_clk, validates the start bit,
//  majority-votes each bit and assembles LSB-first 8N1 frames into a holding register with a valid/ack handshake.
//  Feeds the UART controller, which treats the rising edge of rx_status as "byte received".
// PARAMETERS
//  DATA_BITS    8   data bits per frame (5..8)
//  OVERSAMPLE   16  uart_clk cycles per bit; must be >= 8 and even
//  SYNC_STAGES  2   rxd synchronizer depth (>= 2)
//  PARITY_ODD   0   1 = odd, 0 = even parity; used only with UART_RX_PARITY_EN
// PORTS
//  uart_clk    in   1          16x baud clock
//  reset       in   1          asynchronous, active-low
//  rxd         in   1          serial input, idle high, asynchronous to uart_clk
//  rx_ack      in   1          consumer has taken rx_data; clears rx_full
//  rx_data     out  DATA_BITS  last committed byte
//  rx_valid    out  1          one-cycle pulse on commit
//  rx_full     out  1          holding register unread
//  rx_status   out  1          0 while a validated frame is in progress, else 1
//  frame_err   out  1          stop bit of committed byte sampled 0
//  parity_err  out  1          parity mismatch on committed byte (tied 0 without macro)
//  overrun     out  1          sticky: byte committed while rx_full and no rx_ack
// BEHAVIOUR
//  Reset (async, any state incl. mid-frame): FSM->IDLE, sync flops=1, rx_data=0, rx_valid=0, rx_full=0,
//   rx_status=1, frame_err=0, parity_err=0, overrun=0, counters=0. Frame in progress is discarded.
//  rxd passes SYNC_STAGES flops (rxs); all decisions use rxs. cnt = 0..OVERSAMPLE-1 sample counter.
//  Majority vote: samples at cnt = H-1, H, H+1 (H = OVERSAMPLE/2); decision at cnt = H+1.
//  States:
//   IDLE  : rxs==0 -> START, cnt=0 (that cycle is count 0).
//   START : vote 1 -> IDLE (false start; no output change). vote 0 -> rx_status<=0; at cnt=OVERSAMPLE-1 -> DATA, cnt=0.
//   DATA  : vote shifts into shreg MSB, shreg>>1 (LSB first); after DATA_BITS bits at cnt=OVERSAMPLE-1 -> PARITY/STOP.
//   PARITY: (macro only) one bit time; vote captured, compared to XOR(shreg)^PARITY_ODD.
//   STOP  : at vote (cnt=H+1) commit, no wait for stop-bit end: vote 1 -> IDLE; vote 0 -> BREAK.
//   BREAK : wait for rxs==1, then IDLE; no start detected while rxs stays 0.
//  Commit (single cycle): rx_data<=shreg; rx_valid=1 next cycle only; rx_status<=1; frame_err<=~stop_vote;
//   parity_err<=mismatch; rx_full<=1. Byte is committed even with errors; flags describe that byte.
//  Latency: rx_valid rises SYNC_STAGES + (1+DATA_BITS[+1])*OVERSAMPLE + H + 2 cycles after rxd falls
//   (8N1 defaults: 2+144+8+2 = 156 cycles).
//  Handshake: rx_ack clears rx_full and overrun next cycle; rx_ack while rx_full=0 ignored.
//   Commit with rx_full=1 and no rx_ack: data overwritten, overrun<=1.
//   Commit and rx_ack same cycle: rx_full stays 1, overrun unchanged.
//  Counter wraps at OVERSAMPLE-1 -> 0; bit counter width clog2(DATA_BITS+1).
// CONFIGURATION
//  UART_RX_PARITY_EN defined: frame = start + DATA_BITS + parity + stop; PARITY state active;
//   parity_err valid; latency grows by OVERSAMPLE.
//  Undefined: no PARITY state; frame = start + DATA_BITS + stop; parity_err constant 0; PARITY_ODD ignored.
// TESTING
//  1 8N1 byte 0x55, 16 cycles/bit -> rx_data=0x55, rx_valid 1 cycle at +156, rx_full=1, frame_err=0, rx_status 0->1.
//  2 rxd low 4 cycles then high -> no rx_valid, rx_status stays 1, FSM back in IDLE.
//  3 byte 0xA3 with stop=0, rxd held low 40 cycles -> rx_data=0xA3, frame_err=1; no new frame until rxd high.
//  4 bytes 0x12 then 0x34, no rx_ack -> rx_data=0x34, overrun=1; rx_ack -> rx_full=0, overrun=0.
//  5 reset low at data bit 4 of 0xFF -> all outputs reset values; next clean 0x0F received correctly.
//  6 UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity bit 0 -> parity_err=1; parity bit 1 -> parity_err=0.

Source files
------------

// File: rtl/uart_rx16.sv
// uart_rx16 - receive side of the UART: 16x oversampling, 3-sample majority vote, valid/ack holding register.
// Define UART_RX_PARITY_EN to add a parity bit between the data bits and the stop bit.
module uart_rx16 #(
   parameter int DATA_BITS   = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2,
   parameter int PARITY_ODD  = 0
) (
   input  logic                 uart_clk,
   input  logic                 reset,
   input  logic                 rxd,
   input  logic                 rx_ack,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_full,
   output logic                 rx_status,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam int H  = OVERSAMPLE / 2;

   typedef logic [CW-1:0] cnt_t;
   typedef logic [BW-1:0] bcnt_t;

   localparam cnt_t  C_SAMP0 = cnt_t'(H - 1);
   localparam cnt_t  C_SAMP1 = cnt_t'(H);
   localparam cnt_t  C_VOTE  = cnt_t'(H + 1);
   localparam cnt_t  C_LAST  = cnt_t'(OVERSAMPLE - 1);
   localparam bcnt_t B_ALL   = bcnt_t'(DATA_BITS);

   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
      $error("uart_rx16: DATA_BITS must be 5..8");
   end
   if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
      $error("uart_rx16: OVERSAMPLE must be even and >= 8");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("uart_rx16: SYNC_STAGES must be >= 2");
   end
   if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
      $error("uart_rx16: PARITY_ODD must be 0 or 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxs;

   state_t                 state_q, state_d;
   cnt_t                   cnt_q, cnt_d;
   bcnt_t                  bit_q, bit_d;
   logic [DATA_BITS-1:0]   shreg_q, shreg_d;
   logic [1:0]             samp_q, samp_d;
   logic                   vote;
   logic                   start_ok;
   logic                   commit;

`ifdef UART_RX_PARITY_EN
   logic                   par_q, par_d;
   logic                   mismatch;
   logic                   parity_err_q;
`endif

   assign rxs  = sync_q[SYNC_STAGES-1];
   assign vote = (samp_q[0] & samp_q[1]) |
                 (samp_q[0] & rxs) |
                 (samp_q[1] & rxs);

`ifdef UART_RX_PARITY_EN
   // received parity bit against the parity the data bits call for
   assign mismatch   = par_q ^ (^shreg_q) ^ 1'(PARITY_ODD);
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   // bring the asynchronous line into the uart_clk domain; idle level is 1
   always_ff @(posedge uart_clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
      end
   end

   // frame FSM and datapath registers
   always_ff @(posedge uart_clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         samp_q  <= '1;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         samp_q  <= samp_d;
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // next state, sample capture, bit assembly and commit strobe
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + cnt_t'(1);
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      samp_d   = samp_q;
      start_ok = 1'b0;
      commit   = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d    = par_q;
`endif

      if (cnt_q == C_SAMP0) samp_d[0] = rxs;
      if (cnt_q == C_SAMP1) samp_d[1] = rxs;

      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rxs) begin
               state_d = S_START;
               cnt_d   = cnt_t'(1);
            end
         end
         S_START: begin
            if (cnt_q == C_VOTE) begin
               if (vote) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  start_ok = 1'b1;
               end
            end
            if (cnt_q == C_LAST) begin
               state_d = S_DATA;
               cnt_d   = '0;
            end
         end
         S_DATA: begin
            if (cnt_q == C_VOTE) begin
               shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
               bit_d   = bit_q + bcnt_t'(1);
            end
            if (cnt_q == C_LAST) begin
               cnt_d = '0;
               if (bit_q == B_ALL) begin
                  bit_d = '0;
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (cnt_q == C_VOTE) par_d = vote;
            if (cnt_q == C_LAST) begin
               state_d = S_STOP;
               cnt_d   = '0;
            end
         end
`endif
         S_STOP: begin
            if (cnt_q == C_VOTE) begin
               commit  = 1'b1;
               cnt_d   = '0;
               state_d = vote ? S_IDLE : S_BREAK;
            end
         end
         S_BREAK: begin
            cnt_d = '0;
            if (rxs) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            bit_d   = '0;
         end
      endcase
   end

   // holding register, status flags and valid/ack handshake
   always_ff @(posedge uart_clk or negedge reset) begin
      if (!reset) begin
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_full      <= 1'b0;
         rx_status    <= 1'b1;
         frame_err    <= 1'b0;
         overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         rx_valid <= commit;
         if (start_ok) rx_status <= 1'b0;
         if (commit) begin
            rx_data   <= shreg_q;
            rx_status <= 1'b1;
            frame_err <= ~vote;
            rx_full   <= 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= mismatch;
`endif
            if (rx_full && !rx_ack) overrun <= 1'b1;
         end else if (rx_ack && rx_full) begin
            rx_full <= 1'b0;
            overrun <= 1'b0;
         end
      end
   end

endmodule
